// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared types and constants for the regfile write-back controller.
// Address/data widths, register constants and FSM encoding.
package regfile_wb_ctrl_pkg;

  localparam int AW       = 5;
  localparam int DW       = 32;
  localparam int NUM_REGS = 32;

  localparam logic [AW-1:0] REG_ZERO = 5'd0;
  localparam logic [AW-1:0] REG_LAST = 5'(NUM_REGS - 1);

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  function automatic logic is_eff(
    input logic          we,
    input logic [AW-1:0] a
  );
    return we && (a != REG_ZERO);
  endfunction

endpackage

// File: rtl/regfile_wb_ctrl_if.sv
// Write-back bundle: ALU and load request ports plus regfile write port.
// slave = controller side, master = core/regfile side.
interface regfile_wb_ctrl_if;
  import regfile_wb_ctrl_pkg::*;

  logic          alu_we;
  logic [AW-1:0] alu_wa;
  logic [DW-1:0] alu_wd;
  logic          ld_valid;
  logic [AW-1:0] ld_wa;
  logic [DW-1:0] ld_wd;
  logic          ld_ready;
  logic          werf;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;
  logic          init_done;

  modport slave (
    input  alu_we, alu_wa, alu_wd,
    input  ld_valid, ld_wa, ld_wd,
    output ld_ready,
    output werf, wa, wd,
    output init_done
  );

  modport master (
    output alu_we, alu_wa, alu_wd,
    output ld_valid, ld_wa, ld_wd,
    input  ld_ready,
    input  werf, wa, wd,
    input  init_done
  );

endinterface

// File: rtl/wb_skid_buf.sv
// One-entry load buffer: load, drain (clear) and drop on address match.
// A load in the same cycle as clear/invalidate wins.
module wb_skid_buf
  import regfile_wb_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic          clear,
  input  logic          inv_en,
  input  logic [AW-1:0] inv_addr,
  output logic          valid,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] data
);

  logic          valid_q, valid_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          hit;

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    hit     = inv_en && valid_q && (addr_q == inv_addr);
    if (clear || hit) begin
      valid_d = 1'b0;
      addr_d  = '0;
      data_d  = '0;
    end
    if (load) begin
      valid_d = 1'b1;
      addr_d  = ld_addr;
      data_d  = ld_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign addr  = addr_q;
  assign data  = data_q;

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Regfile write-back arbiter: post-reset sweep of x1..x31, then
// ALU > buffered load > incoming load, with a 1-entry load skid.
module regfile_wb_ctrl
  import regfile_wb_ctrl_pkg::*;
#(
  parameter logic [DW-1:0] INIT_VAL = 32'h0
) (
  input logic              clk,
  input logic              rst,
  regfile_wb_ctrl_if.slave bus
);

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  logic          buf_valid;
  logic [AW-1:0] buf_wa;
  logic [DW-1:0] buf_wd;
  logic          buf_load;
  logic          buf_clear;

  logic          run;
  logic          ld_rdy;
  logic          alu_eff;
  logic          ld_eff;
  logic          we_c;
  logic [AW-1:0] wa_c;
  logic [DW-1:0] wd_c;

  assign run     = (state_q == S_RUN);
  assign ld_rdy  = run && !buf_valid;
  assign alu_eff = run && is_eff(bus.alu_we, bus.alu_wa);
  assign ld_eff  = is_eff(bus.ld_valid && ld_rdy, bus.ld_wa);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_c      = 1'b0;
    wa_c      = '0;
    wd_c      = '0;
    buf_load  = 1'b0;
    buf_clear = 1'b0;
    unique case (state_q)
      S_INIT: begin
        we_c  = 1'b1;
        wa_c  = cnt_q;
        wd_c  = INIT_VAL;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == REG_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        if (alu_eff) begin
          we_c     = 1'b1;
          wa_c     = bus.alu_wa;
          wd_c     = bus.alu_wd;
          // a same-address load is stale against this ALU result
          buf_load = ld_eff && (bus.ld_wa != bus.alu_wa);
        end else if (buf_valid) begin
          we_c      = 1'b1;
          wa_c      = buf_wa;
          wd_c      = buf_wd;
          buf_clear = 1'b1;
        end else if (ld_eff) begin
          we_c = 1'b1;
          wa_c = bus.ld_wa;
          wd_c = bus.ld_wd;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_INIT;
      cnt_q   <= 5'd1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  wb_skid_buf u_buf (
    .clk      (clk),
    .rst      (rst),
    .load     (buf_load),
    .ld_addr  (bus.ld_wa),
    .ld_data  (bus.ld_wd),
    .clear    (buf_clear),
    .inv_en   (alu_eff),
    .inv_addr (bus.alu_wa),
    .valid    (buf_valid),
    .addr     (buf_wa),
    .data     (buf_wd)
  );

  // INIT drives werf from state alone, so reset must gate it directly
  assign bus.werf      = we_c && !rst;
  assign bus.wa        = (we_c && !rst) ? wa_c : '0;
  assign bus.wd        = (we_c && !rst) ? wd_c : '0;
  assign bus.ld_ready  = ld_rdy && !rst;
  assign bus.init_done = run && !rst;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl with a downstream regfile model.
// Inputs driven at negedge, outputs checked 1ns later.
module tb_regfile_wb_ctrl;

  localparam logic [31:0] IV = 32'hA5A5A5A5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic stale_seen = 1'b0;
  logic [31:0] rf [32];

  regfile_wb_ctrl_if bus ();

  regfile_wb_ctrl #(.INIT_VAL(IV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.werf) rf[bus.wa] <= bus.wd;
    if (bus.werf && bus.wd == 32'h22) stale_seen <= 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.alu_we   = 1'b0;
    bus.alu_wa   = '0;
    bus.alu_wd   = '0;
    bus.ld_valid = 1'b0;
    bus.ld_wa    = '0;
    bus.ld_wd    = '0;
  endtask

  task automatic alu(input logic [4:0] a, input logic [31:0] d);
    bus.alu_we = 1'b1;
    bus.alu_wa = a;
    bus.alu_wd = d;
  endtask

  task automatic ld(input logic [4:0] a, input logic [31:0] d);
    bus.ld_valid = 1'b1;
    bus.ld_wa    = a;
    bus.ld_wd    = d;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic zero_out(input string tg);
    chk({tg, "_werf"}, 32'(bus.werf), 0);
    chk({tg, "_wa"}, 32'(bus.wa), 0);
    chk({tg, "_wd"}, bus.wd, 0);
    chk({tg, "_rdy"}, 32'(bus.ld_ready), 0);
    chk({tg, "_done"}, 32'(bus.init_done), 0);
  endtask

  // entered 1ns after the negedge following rst release
  task automatic sweep(input string tg);
    for (int i = 1; i <= 31; i++) begin
      chk({tg, "_werf"}, 32'(bus.werf), 1);
      chk({tg, "_wa"}, 32'(bus.wa), 32'(i));
      chk({tg, "_wd"}, bus.wd, IV);
      chk({tg, "_done0"}, 32'(bus.init_done), 0);
      chk({tg, "_rdy0"}, 32'(bus.ld_ready), 0);
      if (i == 31) idle();
      tick();
      #1;
    end
    chk({tg, "_done1"}, 32'(bus.init_done), 1);
    chk({tg, "_idle"}, 32'(bus.werf), 0);
    chk({tg, "_rdy1"}, 32'(bus.ld_ready), 1);
  endtask

  initial begin
    for (int r = 0; r < 32; r++) rf[r] = '0;
    idle();
    #1;
    zero_out("rst0");
    tick();
    tick();

    // sweep with requests that must be ignored
    alu(5'd7, 32'hDEAD);
    ld(5'd9, 32'hBEEF);
    rst = 1'b0;
    #1;
    sweep("sw1");
    for (int r = 0; r < 32; r++)
      chk($sformatf("rb_x%0d", r), rf[r], (r == 0) ? 32'h0 : IV);

    // ALU alone
    alu(5'd10, 32'd56);
    #1;
    chk("alu_werf", 32'(bus.werf), 1);
    chk("alu_wa", 32'(bus.wa), 10);
    chk("alu_wd", bus.wd, 56);
    tick();
    idle();
    #1;
    chk("alu_rf10", rf[10], 56);
    chk("alu_idle", 32'(bus.werf), 0);

    // ALU beats load, load buffered
    alu(5'd12, 32'd69);
    ld(5'd5, 32'd7);
    #1;
    chk("pri_wa1", 32'(bus.wa), 12);
    chk("pri_wd1", bus.wd, 69);
    chk("pri_rdy1", 32'(bus.ld_ready), 1);
    tick();
    idle();
    #1;
    chk("pri_rf12", rf[12], 69);
    chk("pri_rdy2", 32'(bus.ld_ready), 0);
    chk("pri_werf2", 32'(bus.werf), 1);
    chk("pri_wa2", 32'(bus.wa), 5);
    chk("pri_wd2", bus.wd, 7);
    tick();
    #1;
    chk("pri_rf5", rf[5], 7);
    chk("pri_rdy3", 32'(bus.ld_ready), 1);
    chk("pri_idle", 32'(bus.werf), 0);

    // same-address load is dropped
    alu(5'd3, 32'd1);
    ld(5'd3, 32'd9);
    #1;
    chk("same_wa", 32'(bus.wa), 3);
    chk("same_wd", bus.wd, 1);
    tick();
    idle();
    #1;
    chk("same_rf3", rf[3], 1);
    chk("same_buf", 32'(dut.buf_valid), 0);
    chk("same_rdy", 32'(bus.ld_ready), 1);
    chk("same_idle", 32'(bus.werf), 0);

    // writes to x0
    alu(5'd0, 32'd66);
    ld(5'd0, 32'd66);
    #1;
    chk("x0_werf1", 32'(bus.werf), 0);
    chk("x0_wa1", 32'(bus.wa), 0);
    chk("x0_wd1", bus.wd, 0);
    chk("x0_rdy1", 32'(bus.ld_ready), 1);
    tick();
    idle();
    #1;
    chk("x0_werf2", 32'(bus.werf), 0);
    chk("x0_rdy2", 32'(bus.ld_ready), 1);
    chk("x0_rf0", rf[0], 0);

    // load alone, zero latency
    ld(5'd8, 32'h77);
    #1;
    chk("ld_werf", 32'(bus.werf), 1);
    chk("ld_wa", 32'(bus.wa), 8);
    chk("ld_wd", bus.wd, 32'h77);
    tick();
    idle();
    #1;
    chk("ld_rf8", rf[8], 32'h77);

    // buffered load invalidated by later ALU to same reg
    alu(5'd12, 32'd1);
    ld(5'd6, 32'd2);
    tick();
    idle();
    alu(5'd6, 32'd3);
    #1;
    chk("inv_wa", 32'(bus.wa), 6);
    chk("inv_wd", bus.wd, 3);
    chk("inv_rdy", 32'(bus.ld_ready), 0);
    tick();
    idle();
    #1;
    chk("inv_idle", 32'(bus.werf), 0);
    chk("inv_rdy2", 32'(bus.ld_ready), 1);
    chk("inv_rf6", rf[6], 3);

    // load while buffer full is ignored
    alu(5'd13, 32'h13);
    ld(5'd14, 32'h44);
    tick();
    idle();
    ld(5'd15, 32'h55);
    #1;
    chk("blk_wa", 32'(bus.wa), 14);
    chk("blk_wd", bus.wd, 32'h44);
    chk("blk_rdy", 32'(bus.ld_ready), 0);
    tick();
    idle();
    #1;
    chk("blk_idle", 32'(bus.werf), 0);
    chk("blk_rf14", rf[14], 32'h44);
    chk("blk_rf15", rf[15], IV);

    // reset mid-sweep at cnt=17
    rst = 1'b1;
    #1;
    zero_out("rst1");
    tick();
    rst = 1'b0;
    #1;
    chk("rs_wa1", 32'(bus.wa), 1);
    for (int k = 0; k < 16; k++) tick();
    #1;
    chk("rs_wa17", 32'(bus.wa), 17);
    rst = 1'b1;
    #1;
    zero_out("rst2");
    tick();
    rst = 1'b0;
    #1;
    sweep("sw2");

    // reset with buffer full
    alu(5'd20, 32'h11);
    ld(5'd21, 32'h22);
    tick();
    idle();
    #1;
    chk("bf_full", 32'(dut.buf_valid), 1);
    rst = 1'b1;
    #1;
    zero_out("rst3");
    chk("bf_clr", 32'(dut.buf_valid), 0);
    tick();
    rst = 1'b0;
    #1;
    sweep("sw3");
    tick();
    #1;
    chk("bf_rf21", rf[21], IV);
    chk("bf_stale", 32'(stale_seen), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_ctrl.md
REGFILE_WB_CTRL -- requirements
Module: regfile_wb_ctrl

Interface
REQ-001 SHALL have parameter INIT_VAL, default 32'h0: value written to x1..x31 during the post-reset sweep.
REQ-002 SHALL have ports, one per line: name, direction, width, meaning:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- alu_we  in  1  ALU/immediate result write request; no back-pressure.
- alu_wa  in  5  ALU destination register.
- alu_wd  in  32  ALU result.
- ld_valid  in  1  load data return valid.
- ld_wa  in  5  load destination register.
- ld_wd  in  32  load data.
- ld_ready  out  1  load port can accept this cycle.
- werf  out  1  regfile write enable.
- wa  out  5  regfile write address.
- wd  out  32  regfile write data.
- init_done  out  1  sweep complete; core may run.

Function
REQ-003 SHALL implement a two-state FSM: INIT, RUN. Reset enters INIT.
REQ-004 INIT SHALL hold a 5-bit counter cnt, starting at 1. Each cycle: werf=1, wa=cnt, wd=INIT_VAL. Each edge increments cnt.
REQ-005 On the edge where cnt==31, the FSM SHALL go to RUN and init_done SHALL rise. That is the 31st edge after rst falls.
REQ-006 In INIT, alu_we and ld_valid SHALL be ignored. ld_ready SHALL be 0.
REQ-007 In RUN, werf/wa/wd SHALL be combinational from current inputs and buffer state (zero latency), so the write lands on the same edge.
REQ-008 A request is "effective" only if its address is nonzero. Writes to x0 SHALL never drive werf=1. Load handshakes to x0 SHALL still complete (data discarded).
REQ-009 The block SHALL contain a 1-entry load buffer (buf_valid, buf_wa, buf_wd).
REQ-010 ld_ready SHALL be init_done AND NOT buf_valid. A load handshake is ld_valid AND ld_ready.
REQ-011 RUN write priority SHALL be:
- (1) effective ALU write;
- (2) buffered load;
- (3) effective handshaken incoming load.
REQ-012 A handshaken effective load that loses to an effective ALU write SHALL be captured into the buffer at the edge.
REQ-013 The buffer SHALL drain (buf_valid cleared) on the edge where it drives the port.
REQ-014 Ordering: an effective ALU write SHALL invalidate any buffered load, and any same-cycle incoming load, with the same address (newer ALU result wins, stale load dropped). Captured in the buffer is equivalent to invalidated.
REQ-015 ld_valid while ld_ready==0 SHALL be ignored; the buffer SHALL be unchanged.
REQ-016 When werf==0, wa and wd SHALL be driven 0.

Reset
REQ-017 Asserting rst at any time, including mid-sweep or with the buffer full, SHALL immediately force:
- state=INIT, cnt=1;
- init_done=0, ld_ready=0, buf_valid=0, buf_wa=0, buf_wd=0;
- werf=0, wa=0, wd=0 (werf gated by rst).
REQ-018 The pending buffered load SHALL be lost on reset.
REQ-019 After rst falls, the full sweep SHALL restart from x1.

Structure
REQ-020 A shared package SHALL hold:
- register-address width 5 and data width 32;
- constants NUM_REGS=32 and REG_ZERO=5'd0;
- the FSM state encoding.
REQ-021 The 1-entry load buffer SHALL be a sub-module named wb_skid_buf (valid/addr/data, load/clear/invalidate-on-match inputs).
REQ-022 The controller SHALL connect to regfile through werf/wa/wd unchanged. It SHALL be the regfile's only write source.

Verification
REQ-023 The bench SHALL cover these directed scenarios, each stimulus -> required response:
- Reset, release, INIT_VAL=32'hA5A5A5A5 -> werf=1 for exactly 31 cycles, wa=1..31 in order; init_done rises on the 31st edge; regfile x1..x31 read back A5A5A5A5, x0 reads 0.
- RUN: alu_we=1, alu_wa=10, alu_wd=56 alone -> same-cycle werf=1, wa=10, wd=56; rd of x10 = 56 next cycle.
- Same cycle: alu (wa=12, wd=69) and ld_valid (wa=5, wd=7) -> edge 1 writes x12=69, ld_ready drops; edge 2 writes x5=7, ld_ready returns to 1.
- Same cycle: alu (wa=3, wd=1) and load (wa=3, wd=9) -> x3=1; the load is never written; buf_valid stays 0 after the edge.
- alu_wa=0 with wd=66 and simultaneous load (wa=0, wd=66) -> werf=0 both cycles, ld_ready stays 1, x0 still 0.
- rst pulsed mid-sweep at cnt=17 with buffer empty, and again in RUN with buffer full -> outputs zero during reset; sweep restarts at wa=1; buffered load never written.
